// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
//   Main control FSM for the multi-cycle RISC-V core. One shared ALU, one
//   unified instruction/data memory port and the IR/OldPC/ALUOut/Data holding
//   registers are sequenced over several cycles per instruction.
//   Supported subset: R, I-ALU, LW, SW, BEQ/BNE, JAL, JALR, LUI. Any other
//   opcode lands in an absorbing TRAP state that raises Illegal until rst.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   opcode, funct3    IR[6:0], IR[14:12]
//   Zero              ALU zero flag, meaningful in BRANCH
//   MemReady          memory completes the current request this cycle
//   MemReq/MemWrite   memory request / store strobe
//   AdrSrc            memory address: 0 = PC, 1 = Result
//   IRWrite/PCWrite   load IR+OldPC / load PC from Result
//   RegWrite          register file write
//   ResultSrc         00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
//   ALUSrcA           00 PC, 01 OldPC, 10 RD1
//   ALUSrcB           00 RD2, 01 ImmExt, 10 constant 4
//   ALUOp             00 add, 01 subtract, 10 funct-decoded
//   ImmSrc            I 000, S 001, B 010, U 011, J 100
//   Illegal           trap flag, held while in TRAP
//   Retire            pulse on the final cycle of each instruction
//   CycleCnt/InstretCnt  performance counters
//
// Build option
//   MC_CTRL_PERF_EN   when defined, CycleCnt/InstretCnt are live counters;
//                     otherwise both are tied to 0.
module riscv_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [2:0]  ImmSrc,
  output logic        Illegal,
  output logic        Retire,
  output logic [31:0] CycleCnt,
  output logic [31:0] InstretCnt
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    JALRWB   = 4'd12,
    LUI      = 4'd13,
    TRAP     = 4'd14
  } state_t;

  state_t state;

  // State register. Unreachable encodings fall into TRAP so a corrupted
  // state is visible as Illegal rather than silently executing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (MemReady) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECR;
            OP_I:         state <= EXECI;
            OP_BR:        state <= BRANCH;
            OP_JAL:       state <= JAL;
            OP_JALR:      state <= JALR;
            OP_LUI:       state <= LUI;
            default:      state <= TRAP;
          endcase
        end
        MEMADR:   state <= (opcode == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  if (MemReady) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (MemReady) state <= FETCH;
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        ALUWB:    state <= FETCH;
        BRANCH:   state <= FETCH;
        JAL:      state <= ALUWB;
        JALR:     state <= JALRWB;
        JALRWB:   state <= FETCH;
        LUI:      state <= FETCH;
        TRAP:     state <= TRAP;
        default:  state <= TRAP;
      endcase
    end
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    ImmSrc = 3'b000;
    case (opcode)
      OP_SW:   ImmSrc = 3'b001;
      OP_BR:   ImmSrc = 3'b010;
      OP_LUI:  ImmSrc = 3'b011;
      OP_JAL:  ImmSrc = 3'b100;
      default: ImmSrc = 3'b000;
    endcase
  end

  // Output decode from the state register. Only IRWrite/PCWrite in FETCH,
  // Retire in MEMWRITE and PCWrite in BRANCH look at MemReady/Zero.
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    Illegal   = 1'b0;
    Retire    = 1'b0;
    case (state)
      FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        Retire    = 1'b1;
      end
      MEMWRITE: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        Retire   = MemReady;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Retire  = 1'b1;
        case (funct3)
          3'b000:  PCWrite = Zero;
          3'b001:  PCWrite = ~Zero;
          default: PCWrite = 1'b0;
        endcase
      end
      JAL: begin
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      JALRWB: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
        Retire    = 1'b1;
      end
      LUI: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
        Retire    = 1'b1;
      end
      TRAP:    Illegal = 1'b1;
      default: Illegal = 1'b1;
    endcase
    // The state only returns to FETCH on the edge that samples rst, so the
    // strobes are masked for the reset cycle itself to abandon the
    // in-flight instruction without a stray write.
    if (rst) begin
      MemReq   = 1'b0;
      MemWrite = 1'b0;
      AdrSrc   = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
      Retire   = 1'b0;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  // Both counters stop in TRAP so a dead core doesn't look busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else if (state != TRAP) begin
      cycle_q <= cycle_q + 32'd1;
      if (Retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign CycleCnt   = cycle_q;
  assign InstretCnt = instret_q;
`else
  assign CycleCnt   = 32'd0;
  assign InstretCnt = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed testbench for riscv_multicycle_ctrl. Inputs change 1 ns after the
// rising edge; outputs are compared 1 ns later, well away from the edge.
module tb_riscv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = 7'b0;
  logic [2:0]  funct3 = 3'b0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b1;
  logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0]  ImmSrc;
  logic        Illegal, Retire;
  logic [31:0] CycleCnt, InstretCnt;

  int chks = 0;
  int errs = 0;

  riscv_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .Zero(Zero),
    .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .Illegal(Illegal), .Retire(Retire),
    .CycleCnt(CycleCnt), .InstretCnt(InstretCnt)
  );

  always #5 clk = ~clk;

  // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,Illegal,Retire}
  logic [15:0] obs;
  assign obs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal, Retire};

  function automatic logic [15:0] e(input logic mr, mw, as, irw, pcw, rw,
                                    input logic [1:0] rs, sa, sb, op,
                                    input logic ill, ret);
    return {mr, mw, as, irw, pcw, rw, rs, sa, sb, op, ill, ret};
  endfunction

  logic [15:0] E_FETCH, E_FETCH_W, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB,
               E_MEMWR_W, E_MEMWR, E_EXECR, E_EXECI, E_ALUWB, E_BR_NT, E_BR_T,
               E_JAL, E_JALR, E_JALRWB, E_LUI, E_TRAP, E_RST_FETCH;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                         OP_R = 7'b0110011, OP_BR = 7'b1100011,
                         OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_LUI = 7'b0110111;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] x;
    rst = 1'b1; MemReady = 1'b1; opcode = OP_R;
    tick(); tick();
    x = E_RST_FETCH; if (obs !== x) begin errs++; $display("FAIL reset_hold: got %h exp %h", obs, x); end chks++;
    if (CycleCnt !== 32'd0) begin errs++; $display("FAIL reset_cyc: got %0d exp 0", CycleCnt); end chks++;
    if (InstretCnt !== 32'd0) begin errs++; $display("FAIL reset_ret: got %0d exp 0", InstretCnt); end chks++;
    rst = 1'b0; #1;
    x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL reset_fetch: got %h exp %h", obs, x); end chks++;
  endtask

  task automatic test_add();
    logic [15:0] x;
    opcode = OP_R; MemReady = 1'b1; #1;
    x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL add_c1: got %h exp %h", obs, x); end chks++;
    if (ImmSrc !== 3'b000) begin errs++; $display("FAIL add_imm: got %b exp 000", ImmSrc); end chks++;
    tick();
    x = E_DECODE; if (obs !== x) begin errs++; $display("FAIL add_c2: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_EXECR; if (obs !== x) begin errs++; $display("FAIL add_c3: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_ALUWB; if (obs !== x) begin errs++; $display("FAIL add_c4: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL add_next: got %h exp %h", obs, x); end chks++;
  endtask

  task automatic test_lw();
    logic [15:0] x;
    opcode = OP_LW; MemReady = 1'b1; #1;
    x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL lw_c1: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_DECODE; if (obs !== x) begin errs++; $display("FAIL lw_c2: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_MEMADR; if (obs !== x) begin errs++; $display("FAIL lw_c3: got %h exp %h", obs, x); end chks++;
    tick(); MemReady = 1'b0; #1;
    x = E_MEMREAD; if (obs !== x) begin errs++; $display("FAIL lw_c4: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_MEMREAD; if (obs !== x) begin errs++; $display("FAIL lw_c5: got %h exp %h", obs, x); end chks++;
    tick(); MemReady = 1'b1; #1;
    x = E_MEMREAD; if (obs !== x) begin errs++; $display("FAIL lw_c6: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_MEMWB; if (obs !== x) begin errs++; $display("FAIL lw_c7: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL lw_next: got %h exp %h", obs, x); end chks++;
  endtask

  task automatic test_sw_waits();
    logic [15:0] x;
    opcode = OP_SW; MemReady = 1'b0; #1;
    x = E_FETCH_W; if (obs !== x) begin errs++; $display("FAIL sw_fwait: got %h exp %h", obs, x); end chks++;
    if (ImmSrc !== 3'b001) begin errs++; $display("FAIL sw_imm: got %b exp 001", ImmSrc); end chks++;
    tick();
    x = E_FETCH_W; if (obs !== x) begin errs++; $display("FAIL sw_fwait2: got %h exp %h", obs, x); end chks++;
    MemReady = 1'b1; #1;
    x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL sw_fetch: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_DECODE; if (obs !== x) begin errs++; $display("FAIL sw_dec: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_MEMADR; if (obs !== x) begin errs++; $display("FAIL sw_adr: got %h exp %h", obs, x); end chks++;
    tick(); MemReady = 1'b0; #1;
    x = E_MEMWR_W; if (obs !== x) begin errs++; $display("FAIL sw_wwait: got %h exp %h", obs, x); end chks++;
    tick(); MemReady = 1'b1; #1;
    x = E_MEMWR; if (obs !== x) begin errs++; $display("FAIL sw_wdone: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL sw_next: got %h exp %h", obs, x); end chks++;
  endtask

  task automatic test_branch();
    logic [15:0] x;
    logic [2:0]  f3s [4];
    logic        zs  [4];
    logic        tk  [4];
    f3s = '{3'b001, 3'b001, 3'b000, 3'b010};
    zs  = '{1'b0,   1'b1,   1'b1,   1'b1};
    tk  = '{1'b1,   1'b0,   1'b1,   1'b0};
    for (int i = 0; i < 4; i++) begin
      opcode = OP_BR; funct3 = f3s[i]; Zero = zs[i]; MemReady = 1'b1; #1;
      x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL br%0d_c1: got %h exp %h", i, obs, x); end chks++;
      if (ImmSrc !== 3'b010) begin errs++; $display("FAIL br%0d_imm: got %b exp 010", i, ImmSrc); end chks++;
      tick();
      x = E_DECODE; if (obs !== x) begin errs++; $display("FAIL br%0d_c2: got %h exp %h", i, obs, x); end chks++;
      tick();
      x = tk[i] ? E_BR_T : E_BR_NT;
      if (obs !== x) begin errs++; $display("FAIL br%0d_c3: got %h exp %h", i, obs, x); end chks++;
      tick();
      x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL br%0d_next: got %h exp %h", i, obs, x); end chks++;
    end
    funct3 = 3'b000; Zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [15:0] x;
    opcode = OP_JAL; MemReady = 1'b1; #1;
    if (ImmSrc !== 3'b100) begin errs++; $display("FAIL jal_imm: got %b exp 100", ImmSrc); end chks++;
    tick();
    x = E_DECODE; if (obs !== x) begin errs++; $display("FAIL jal_c2: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_JAL; if (obs !== x) begin errs++; $display("FAIL jal_c3: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_ALUWB; if (obs !== x) begin errs++; $display("FAIL jal_c4: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL jal_next: got %h exp %h", obs, x); end chks++;
  endtask

  task automatic test_jalr();
    logic [15:0] x;
    opcode = OP_JALR; MemReady = 1'b1; #1;
    if (ImmSrc !== 3'b000) begin errs++; $display("FAIL jalr_imm: got %b exp 000", ImmSrc); end chks++;
    tick(); tick();
    x = E_JALR; if (obs !== x) begin errs++; $display("FAIL jalr_c3: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_JALRWB; if (obs !== x) begin errs++; $display("FAIL jalr_c4: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL jalr_next: got %h exp %h", obs, x); end chks++;
  endtask

  task automatic test_mid_reset();
    logic [15:0] x;
    opcode = OP_SW; MemReady = 1'b1; #1;
    tick(); tick(); tick(); MemReady = 1'b0; #1;
    x = E_MEMWR_W; if (obs !== x) begin errs++; $display("FAIL mrst_wr: got %h exp %h", obs, x); end chks++;
    rst = 1'b1; #1;
    x = 16'h0000; if (obs !== x) begin errs++; $display("FAIL mrst_mask: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_RST_FETCH; if (obs !== x) begin errs++; $display("FAIL mrst_hold: got %h exp %h", obs, x); end chks++;
    rst = 1'b0; MemReady = 1'b1; #1;
    x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL mrst_fetch: got %h exp %h", obs, x); end chks++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] x;
    int bad = 0;
    rst = 1'b1; MemReady = 1'b1; opcode = OP_LUI; tick(); rst = 1'b0; #1;
    if (ImmSrc !== 3'b011) begin errs++; $display("FAIL lui_imm: got %b exp 011", ImmSrc); end chks++;
    for (int i = 0; i < 10; i++) begin
      if (obs !== E_FETCH) bad++;
      tick();
      if (obs !== E_DECODE) bad++;
      tick();
      if (obs !== E_LUI) bad++;
      tick();
    end
    if (bad != 0) begin errs++; $display("FAIL b2b_seq: got %0d bad cycles exp 0", bad); end chks++;
    x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL b2b_next: got %h exp %h", obs, x); end chks++;
`ifdef MC_CTRL_PERF_EN
    if (InstretCnt !== 32'd10) begin errs++; $display("FAIL b2b_ret: got %0d exp 10", InstretCnt); end chks++;
    if (CycleCnt !== 32'd30) begin errs++; $display("FAIL b2b_cyc: got %0d exp 30", CycleCnt); end chks++;
`else
    if (InstretCnt !== 32'd0) begin errs++; $display("FAIL b2b_ret: got %0d exp 0", InstretCnt); end chks++;
    if (CycleCnt !== 32'd0) begin errs++; $display("FAIL b2b_cyc: got %0d exp 0", CycleCnt); end chks++;
`endif
  endtask

  task automatic test_illegal();
    logic [15:0] x;
    int bad = 0;
    rst = 1'b1; MemReady = 1'b1; opcode = 7'b0000000; tick(); rst = 1'b0; #1;
    x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL ill_c1: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_DECODE; if (obs !== x) begin errs++; $display("FAIL ill_c2: got %h exp %h", obs, x); end chks++;
    tick();
    x = E_TRAP; if (obs !== x) begin errs++; $display("FAIL ill_c3: got %h exp %h", obs, x); end chks++;
    for (int i = 0; i < 20; i++) begin
      if (obs !== E_TRAP) bad++;
`ifdef MC_CTRL_PERF_EN
      if (CycleCnt !== 32'd2 || InstretCnt !== 32'd0) bad++;
`endif
      tick();
    end
    if (bad != 0) begin errs++; $display("FAIL ill_hold: got %0d bad cycles exp 0", bad); end chks++;
    rst = 1'b1; #1;
    x = 16'h0000; if (obs !== x) begin errs++; $display("FAIL ill_rst: got %h exp %h", obs, x); end chks++;
    tick(); rst = 1'b0; opcode = OP_R; #1;
    x = E_FETCH; if (obs !== x) begin errs++; $display("FAIL ill_fetch: got %h exp %h", obs, x); end chks++;
    if (Illegal !== 1'b0) begin errs++; $display("FAIL ill_clear: got %b exp 0", Illegal); end chks++;
  endtask

  initial begin
    E_FETCH     = e(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,0,0);
    E_FETCH_W   = e(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0);
    E_RST_FETCH = e(0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,0);
    E_DECODE    = e(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0);
    E_MEMADR    = e(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0);
    E_MEMREAD   = e(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0);
    E_MEMWB     = e(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,0,1);
    E_MEMWR_W   = e(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0);
    E_MEMWR     = e(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1);
    E_EXECR     = e(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0);
    E_EXECI     = e(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0,0);
    E_ALUWB     = e(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0,1);
    E_BR_NT     = e(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,0,1);
    E_BR_T      = e(0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b01,0,1);
    E_JAL       = e(0,0,0,0,1,0,2'b00,2'b01,2'b10,2'b00,0,0);
    E_JALR      = e(0,0,0,0,1,0,2'b10,2'b10,2'b01,2'b00,0,0);
    E_JALRWB    = e(0,0,0,0,0,1,2'b10,2'b01,2'b10,2'b00,0,1);
    E_LUI       = e(0,0,0,0,0,1,2'b11,2'b00,2'b00,2'b00,0,1);
    E_TRAP      = e(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0);

    test_reset();
    test_add();
    test_lw();
    test_sw_waits();
    test_branch();
    test_jal();
    test_jalr();
    test_mid_reset();
    test_back_to_back();
    test_illegal();

    $display("Simulation finished: %0d checks, %0d errors", chks, errs);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Main control FSM for the multi-cycle RISC-V core variant: sequences a single shared ALU, a unified instruction/data memory port, and the IR/OldPC/ALUOut/Data holding registers over several cycles per instruction. It decodes `opcode`/`funct3` from the instruction register. It drives every datapath select and write strobe, and it stalls on a memory ready handshake. It supports the same instruction subset as the pipelined decoder: R, I-ALU, LW, SW, BEQ/BNE, JAL, JALR, LUI.

## Interface
- No parameters.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; one clock, reset is synchronous and active-high.
- `opcode` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `Zero` in 1: ALU zero flag, valid in BRANCH.
- `MemReady` in 1: memory completes the current request this cycle.
- `MemReq` out 1: memory request active.
- `MemWrite` out 1: store strobe.
- `AdrSrc` out 1: 0 = PC, 1 = Result.
- `IRWrite` out 1: load IR and OldPC.
- `PCWrite` out 1: load PC from Result.
- `RegWrite` out 1: register file write.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 RD1.
- `ALUSrcB` out 2: 00 RD2, 01 ImmExt, 10 constant 4.
- `ALUOp` out 2: 00 add, 01 subtract, 10 funct-decoded.
- `ImmSrc` out 3: I 000, S 001, B 010, U 011, J 100.
- `Illegal` out 1: sticky trap flag.
- `Retire` out 1: one-cycle pulse on the final cycle of each instruction.
- `CycleCnt` out 32: performance counter (see Configuration).
- `InstretCnt` out 32: performance counter (see Configuration).

## Operation
- **State encoding:** FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALRWB 12, LUI 13, TRAP 14.
- **Output defaults:** all strobes 0. `ResultSrc`, `ALUSrcA`, `ALUSrcB` and `ALUOp` are 00 unless listed below.
- **`ImmSrc`:** decoded combinationally from `opcode` in every state. Unknown opcodes give 000.
- **FETCH**
  - Outputs: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - IRWrite and PCWrite equal MemReady.
  - Stay in FETCH while !MemReady; otherwise go to DECODE.
- **DECODE**
  - Outputs: ALUSrcA=01, ALUSrcB=01 (branch/JAL target into ALUOut).
  - Next state by opcode: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111 → LUI; any other → TRAP.
- **MEMADR**
  - Outputs: ALUSrcA=10, ALUSrcB=01.
  - Next: MEMREAD for a load, MEMWRITE for a store.
- **MEMREAD**
  - Outputs: MemReq=1, AdrSrc=1.
  - Hold until MemReady, then go to MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=1; next FETCH.
- **MEMWRITE**
  - Outputs: MemReq=1, AdrSrc=1, MemWrite=1, all held until MemReady.
  - Then go to FETCH.
- **EXECR:** ALUSrcA=10, ALUSrcB=00, ALUOp=10; next ALUWB.
- **EXECI:** ALUSrcA=10, ALUSrcB=01, ALUOp=10; next ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=1; next FETCH.
- **BRANCH**
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite = Zero for funct3 000, !Zero for funct3 001, 0 for any other funct3 (not taken, no trap).
  - Next FETCH.
- **JAL**
  - Outputs: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10 (OldPC+4 into ALUOut).
  - Next ALUWB.
- **JALR**
  - Outputs: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCWrite=1.
  - Next JALRWB.
- **JALRWB:** ALUSrcA=01, ALUSrcB=10, ResultSrc=10, RegWrite=1; next FETCH.
- **LUI:** ResultSrc=11, RegWrite=1; next FETCH.
- **TRAP**
  - All strobes 0, Illegal=1.
  - Absorbing state; only `rst` exits.
- **Retire:** high in MEMWB, MEMWRITE&&MemReady, ALUWB, BRANCH, JALRWB and LUI.

## Timing
- **Moore outputs:** all outputs depend on the state register only, except the MemReady- and Zero-qualified strobes.
- **Cycles per instruction with MemReady tied high:** LUI 3, BEQ/BNE 3, R 4, I-ALU 4, SW 4, JAL 4, JALR 4, LW 5.
- **Memory wait:** each extra cycle of MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs are stable while waiting.
- **Reset:** while `rst`=1 all strobes, MemReq, Retire and Illegal are 0. The state is FETCH on the following edge.
- **Reset mid-instruction:** the instruction is abandoned; no write strobes are issued after reset asserts.
- **Illegal:** asserts on the first cycle after DECODE sees an unknown opcode.

## Configuration
- **`MC_CTRL_PERF_EN` defined:**
  - `CycleCnt` increments every non-reset cycle.
  - `InstretCnt` increments on each Retire.
  - Both are cleared by `rst`, wrap from 0xFFFFFFFF to 0, and both freeze in TRAP.
- **Undefined:** both ports are constant 0 and no counter registers are inferred.

## Test plan
- `add` (0110011) with MemReady=1 → states 0,1,6,8. RegWrite=1 only in cycle 4, where Retire=1 too.
- `lw` with MemReady low for 2 cycles in MEMREAD → 7 total cycles; AdrSrc=1 and MemReq=1 held; RegWrite with ResultSrc=01 in the last cycle.
- `bne` (funct3 001): Zero=0 → PCWrite=1 in BRANCH; Zero=1 → PCWrite=0. Both cases take 3 cycles.
- `jalr` → PCWrite=1 with ResultSrc=10 in JALR. Next cycle RegWrite=1, ALUSrcA=01, ALUSrcB=10.
- Opcode 0000000 → Illegal=1 from cycle 3 on, no strobes for 20 cycles. `rst` pulse → FETCH, Illegal=0.
- With `MC_CTRL_PERF_EN`, 10 back-to-back LUIs → InstretCnt=10, CycleCnt=30.
